// File: rtl/sdes_pkg.sv
// Shared S-DES S-box constants and index helpers for the pipelined lookup engine.
// The S0/S1 tables are stored row-major as [row][col].
package sdes_pkg;

  localparam logic [1:0] S0_TBL [4][4] = '{
    '{2'd1, 2'd0, 2'd3, 2'd2},
    '{2'd3, 2'd2, 2'd1, 2'd0},
    '{2'd0, 2'd2, 2'd1, 2'd3},
    '{2'd3, 2'd1, 2'd3, 2'd2}
  };

  localparam logic [1:0] S1_TBL [4][4] = '{
    '{2'd0, 2'd1, 2'd2, 2'd3},
    '{2'd2, 2'd0, 2'd1, 2'd3},
    '{2'd3, 2'd0, 2'd1, 2'd0},
    '{2'd2, 2'd1, 2'd0, 2'd3}
  };

  // Outer bits form the row, inner bits the column; result is {row, col}.
  function automatic int sbox_index(input int x, input int col_bits);
    int row;
    int col;
    row = (((x >> (col_bits + 1)) & 1) << 1) | (x & 1);
    col = (x >> 1) & ((1 << col_bits) - 1);
    return (row << col_bits) | col;
  endfunction

  function automatic int default_entry(input int lane, input int i, input int col_bits,
                                       input int out_w);
    logic [1:0] r;
    logic [1:0] c;
    r = 2'((i >> 2) & 3);
    c = 2'(i & 3);
    if (col_bits == 2 && out_w == 2) begin
      if ((lane % 2) == 0) return int'(S0_TBL[r][c]);
      return int'(S1_TBL[r][c]);
    end
    return i & ((1 << out_w) - 1);
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One S-box lane: writable substitution table with reset defaults and a registered read.
// A read and a write to the same entry on one edge return the pre-write contents.
module sbox_lane
  import sdes_pkg::*;
#(
  parameter int LANE     = 0,
  parameter int COL_BITS = 2,
  parameter int OUT_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [COL_BITS+1:0]   i_waddr,
  input  logic [OUT_W-1:0]      i_wdata,
  input  logic                  i_rd_en,
  input  logic [COL_BITS+1:0]   i_raddr,
  output logic [OUT_W-1:0]      o_rdata
);

  localparam int IN_W  = COL_BITS + 2;
  localparam int DEPTH = 1 << IN_W;

  logic [OUT_W-1:0] r_tbl [DEPTH];
  logic [OUT_W-1:0] r_rdata_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tbl[IN_W'(i)] <= OUT_W'(default_entry(LANE, i, COL_BITS, OUT_W));
      end
      r_rdata_p2 <= '0;
    end else begin
      if (i_we) r_tbl[i_waddr] <= i_wdata;
      if (i_rd_en) r_rdata_p2 <= r_tbl[i_raddr];
    end
  end

  assign o_rdata = r_rdata_p2;

endmodule

// File: rtl/sbox_pipe.sv
// Multi-lane S-box lookup engine with a 2-stage valid/ready pipeline:
// stage 1 holds the decoded {row,col} indices, stage 2 holds the table read.
module sbox_pipe
  import sdes_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int COL_BITS  = 2,
  parameter int OUT_W     = 2,
  localparam int IN_W     = COL_BITS + 2,
  localparam int LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_LANES*IN_W-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_LANES*OUT_W-1:0] out_data,
  input  logic                      cfg_we,
  input  logic [LANE_W-1:0]         cfg_lane,
  input  logic [IN_W-1:0]           cfg_addr,
  input  logic [OUT_W-1:0]          cfg_data
);

  logic w_adv1;
  logic w_adv2;
  logic r_vld_p1;
  logic r_vld_p2;

  // A stage may load when it is empty or its content moves on this edge.
  assign w_adv2    = !r_vld_p2 || out_ready;
  assign w_adv1    = !r_vld_p1 || w_adv2;
  assign in_ready  = w_adv1;
  assign out_valid = r_vld_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      if (w_adv1) r_vld_p1 <= in_valid;
      if (w_adv2) r_vld_p2 <= r_vld_p1;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [IN_W-1:0] w_idx;
    logic [IN_W-1:0] r_idx_p1;
    logic            w_we;

    assign w_idx = IN_W'(sbox_index(int'(in_data[l*IN_W +: IN_W]), COL_BITS));
    assign w_we  = cfg_we && (int'(cfg_lane) == l);

    // Stage 1: decoded index
    always_ff @(posedge clk) begin
      if (w_adv1 && in_valid) r_idx_p1 <= w_idx;
    end

    // Stage 2: table read lands directly in the output register
    sbox_lane #(
      .LANE     (l),
      .COL_BITS (COL_BITS),
      .OUT_W    (OUT_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we),
      .i_waddr (cfg_addr),
      .i_wdata (cfg_data),
      .i_rd_en (w_adv2 && r_vld_p1),
      .i_raddr (r_idx_p1),
      .o_rdata (out_data[l*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_sbox_pipe.sv
// Bench for sbox_pipe: default 2-lane geometry plus 4-lane and 3-lane identity geometries.
module tb_sbox_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, cfg_we;
  logic [7:0] in_data;
  logic [3:0] out_data;
  logic [0:0] cfg_lane;
  logic [3:0] cfg_addr;
  logic [1:0] cfg_data;

  logic        d4_in_valid, d4_in_ready, d4_out_valid, d4_cfg_we;
  logic [19:0] d4_in_data;
  logic [11:0] d4_out_data;
  logic [1:0]  d4_cfg_lane;
  logic [4:0]  d4_cfg_addr;
  logic [2:0]  d4_cfg_data;

  logic        d3_in_valid, d3_in_ready, d3_out_valid, d3_cfg_we;
  logic [14:0] d3_in_data;
  logic [8:0]  d3_out_data;
  logic [1:0]  d3_cfg_lane;
  logic [4:0]  d3_cfg_addr;
  logic [2:0]  d3_cfg_data;

  sbox_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_lane(cfg_lane), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
  );

  sbox_pipe #(.NUM_LANES(4), .COL_BITS(3), .OUT_W(3)) dut4 (
    .clk(clk), .rst(rst), .in_valid(d4_in_valid), .in_ready(d4_in_ready), .in_data(d4_in_data),
    .out_valid(d4_out_valid), .out_ready(1'b1), .out_data(d4_out_data),
    .cfg_we(d4_cfg_we), .cfg_lane(d4_cfg_lane), .cfg_addr(d4_cfg_addr), .cfg_data(d4_cfg_data)
  );

  sbox_pipe #(.NUM_LANES(3), .COL_BITS(3), .OUT_W(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(d3_in_valid), .in_ready(d3_in_ready), .in_data(d3_in_data),
    .out_valid(d3_out_valid), .out_ready(1'b1), .out_data(d3_out_data),
    .cfg_we(d3_cfg_we), .cfg_lane(d3_cfg_lane), .cfg_addr(d3_cfg_addr), .cfg_data(d3_cfg_data)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_emit = 0;
  int mdl [2][4][4];
  logic [3:0] exp_q [$];

  typedef struct {
    logic [7:0] din;
    logic [3:0] dout;
  } vec_t;
  vec_t vt [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void init_mdl();
    mdl = '{
      '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}},
      '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}}
    };
  endfunction

  // Row from the two outer bits, column from the two inner bits.
  function automatic int ref_out(input int lane, input int x);
    int row, col;
    row = ((x >> 3) & 1) * 2 + (x & 1);
    col = (x >> 1) & 3;
    return mdl[lane][row][col];
  endfunction

  function automatic logic [3:0] ref_word(input logic [7:0] d);
    return {2'(ref_out(1, int'(d[7:4]))), 2'(ref_out(0, int'(d[3:0])))};
  endfunction

  function automatic logic [2:0] ref_ident(input int x);
    int idx;
    idx = (((x >> 4) & 1) << 4) | ((x & 1) << 3) | ((x >> 1) & 7);
    return 3'(idx % 8);
  endfunction

  // One clock of the main DUT with scoreboard bookkeeping on both handshakes.
  task automatic cycle(output bit acc);
    bit emt;
    logic [3:0] od;
    #1;
    acc = in_valid && in_ready;
    emt = out_valid && out_ready;
    od  = out_data;
    if (acc) exp_q.push_back(ref_word(in_data));
    @(posedge clk);
    #1;
    if (emt) begin
      n_emit++;
      if (exp_q.size() == 0) check("sb_unexpected_emit", 32'(od), 32'hFFFF);
      else check("sb_data", 32'(od), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    bit acc;
    bit all_rdy;
    int e0, k;
    logic [3:0] held;
    logic [7:0] w [4];
    logic [19:0] d4v;
    logic [11:0] d4e;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_lane = '0; cfg_addr = '0; cfg_data = '0;
    d4_in_valid = 1'b0; d4_in_data = '0; d4_cfg_we = 1'b0; d4_cfg_lane = '0;
    d4_cfg_addr = '0; d4_cfg_data = '0;
    d3_in_valid = 1'b0; d3_in_data = '0; d3_cfg_we = 1'b0; d3_cfg_lane = '0;
    d3_cfg_addr = '0; d3_cfg_data = '0;
    init_mdl();

    vt[0] = '{din: 8'h14, dout: 4'b1011};
    vt[1] = '{din: 8'h00, dout: 4'b0001};
    vt[2] = '{din: 8'hFF, dout: 4'b1110};
    vt[3] = '{din: 8'h68, dout: 4'b1100};
    vt[4] = '{din: 8'hA3, dout: 4'b0010};

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_d4_out_data", 32'(d4_out_data), 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = vt[i].din;
      cycle(acc);
      in_valid = 1'b0;
      check("vec_accept", 32'(acc), 1);
      check("vec_lat1_valid", 32'(out_valid), 0);
      cycle(acc);
      check("vec_valid", 32'(out_valid), 1);
      check("vec_data", 32'(out_data), 32'(vt[i].dout));
    end
    cycle(acc);

    // Back-to-back sweep over all inputs on both lanes
    e0 = n_emit;
    all_rdy = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = {4'(15 - i), 4'(i)};
      cycle(acc);
      if (!acc) all_rdy = 1'b0;
    end
    in_valid = 1'b0;
    cycle(acc);
    cycle(acc);
    check("stream_all_accepted", 32'(all_rdy), 1);
    check("stream_emit_count", 32'(n_emit - e0), 16);

    // Backpressure: fill both stages, stall three cycles, release
    e0 = n_emit;
    for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = w[0];
    cycle(acc);
    in_data = w[1];
    cycle(acc);
    in_data = w[2];
    check("bp_in_ready_low", 32'(in_ready), 0);
    held = out_data;
    repeat (3) begin
      cycle(acc);
      check("bp_no_accept", 32'(acc), 0);
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_data", 32'(out_data), 32'(held));
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_same_cycle", 32'(in_ready), 1);
    k = 2;
    for (int t = 0; t < 20 && (k < 4 || exp_q.size() > 0); t++) begin
      cycle(acc);
      if (acc) begin
        k++;
        if (k < 4) in_data = w[k];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("bp_all_sent", 32'(k), 4);
    check("bp_queue_empty", 32'(exp_q.size()), 0);
    check("bp_emit_count", 32'(n_emit - e0), 4);

    // Table write colliding with a stage-2 read of the same entry
    in_valid = 1'b1;
    in_data  = 8'h00;
    cycle(acc);
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_lane = 1'b0; cfg_addr = 4'b0000; cfg_data = 2'b10;
    cycle(acc);
    cfg_we = 1'b0;
    mdl[0][0][0] = 2;
    check("coll_old_value", 32'(out_data[1:0]), 32'(2'b01));
    in_valid = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    cycle(acc);
    check("coll_new_value", 32'(out_data[1:0]), 32'(2'b10));
    cycle(acc);

    // Reset with two words in flight, plus a write attempted during reset
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'($urandom);
    cycle(acc);
    in_data = 8'($urandom);
    cycle(acc);
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    cfg_we = 1'b1; cfg_lane = 1'b0; cfg_addr = 4'b0000; cfg_data = 2'b11;
    cycle(acc);
    check("rst_drop_valid", 32'(out_valid), 0);
    check("rst_drop_data", 32'(out_data), 0);
    rst = 1'b0;
    cfg_we = 1'b0;
    exp_q.delete();
    init_mdl();
    out_ready = 1'b1;
    repeat (3) begin
      cycle(acc);
      check("rst_no_emit", 32'(out_valid), 0);
    end
    in_valid = 1'b1;
    in_data  = 8'h00;
    cycle(acc);
    in_valid = 1'b0;
    cycle(acc);
    check("rst_default_restored", 32'(out_data[1:0]), 32'(2'b01));
    cycle(acc);

    // Random traffic with random backpressure against the model
    e0 = n_emit;
    k = 0;
    for (int t = 0; t < 200; t++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(acc);
      if (acc) k++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 6 && exp_q.size() > 0; t++) cycle(acc);
    check("rand_drained", 32'(exp_q.size()), 0);
    check("rand_emit_count", 32'(n_emit - e0), 32'(k));

    // 4-lane, 3-bit column geometry: identity defaults
    d4_in_data  = {4{5'b10110}};
    d4_in_valid = 1'b1;
    @(posedge clk); #1;
    d4_in_valid = 1'b0;
    @(posedge clk); #1;
    check("g4_valid", 32'(d4_out_valid), 1);
    check("g4_ident_10110", 32'(d4_out_data), 32'({4{3'b011}}));
    for (int t = 0; t < 6; t++) begin
      for (int l = 0; l < 4; l++) begin
        int x;
        x = $urandom_range(0, 31);
        d4v[l*5 +: 5] = 5'(x);
        d4e[l*3 +: 3] = ref_ident(x);
      end
      d4_in_data  = d4v;
      d4_in_valid = 1'b1;
      @(posedge clk); #1;
      d4_in_valid = 1'b0;
      @(posedge clk); #1;
      check("g4_ident_rand", 32'(d4_out_data), 32'(d4e));
    end

    // 3-lane geometry: out-of-range lane write ignored, in-range write lands
    d3_cfg_we = 1'b1; d3_cfg_lane = 2'd3; d3_cfg_addr = 5'b10011; d3_cfg_data = 3'b111;
    @(posedge clk); #1;
    d3_cfg_we = 1'b0;
    d3_in_data  = {3{5'b10110}};
    d3_in_valid = 1'b1;
    @(posedge clk); #1;
    d3_in_valid = 1'b0;
    @(posedge clk); #1;
    check("g3_oor_ignored", 32'(d3_out_data), 32'({3{3'b011}}));
    d3_cfg_we = 1'b1; d3_cfg_lane = 2'd2; d3_cfg_data = 3'b101;
    @(posedge clk); #1;
    d3_cfg_we = 1'b0;
    d3_in_valid = 1'b1;
    @(posedge clk); #1;
    d3_in_valid = 1'b0;
    @(posedge clk); #1;
    check("g3_lane2_write", 32'(d3_out_data), 32'({3'b101, 3'b011, 3'b011}));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "time limit");
  end

endmodule
